// File: rtl/dtw_traceback_pkg.sv
// ---------------------------------------------------------------------------
// dtw_traceback_pkg
// Shared definitions for the DTW traceback block and the distance-compute
// array that feeds it: lane geometry, index widths, predecessor code values
// and lane slice helpers. Keeping them here keeps the code meanings in
// lock-step between producer and consumer.
// ---------------------------------------------------------------------------
package dtw_traceback_pkg;

  localparam int LANES  = 6;           // cells delivered per cycle
  localparam int IDX_W  = 5;           // sequence index width
  localparam int PLEN_W = 6;           // path length counter width
  localparam int CODE_W = 2;           // predecessor code width
  localparam int DEPTH  = 1 << IDX_W;  // cells per store dimension

  // Predecessor codes written by the array for every cell
  typedef enum logic [CODE_W-1:0] {
    PC_DIAG = 2'b00,   // came from (t-1, r-1)
    PC_UP   = 2'b01,   // came from (t-1, r)
    PC_LEFT = 2'b10,   // came from (t,   r-1)
    PC_NONE = 2'b11    // idle lane / unwritten cell
  } path_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FILL  = 2'b01,
    ST_TRACE = 2'b10
  } state_e;

  // Lane 0 occupies the most significant slice of each packed lane bus
  function automatic logic [CODE_W-1:0] lane_code(
    input logic [LANES*CODE_W-1:0] path,
    input int                      k
  );
    return path[(LANES-1-k)*CODE_W +: CODE_W];
  endfunction

  function automatic logic [IDX_W-1:0] lane_idx(
    input logic [LANES*IDX_W-1:0] idx,
    input int                     k
  );
    return idx[(LANES-1-k)*IDX_W +: IDX_W];
  endfunction

endpackage

// File: rtl/dtw_traceback_mem.sv
// ---------------------------------------------------------------------------
// dtw_traceback_mem
// Flop-based predecessor store: DEPTH x DEPTH cells of CODE_W bits.
// LANES write ports (higher lane index wins on a same-cycle collision),
// one asynchronous read port, and a single-cycle bulk clear to PC_NONE.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (store -> PC_NONE)
//   i_clr         clear every cell to PC_NONE this cycle (overrides writes)
//   i_we          per-lane write enable (already qualified by caller)
//   i_path        packed lane codes
//   i_tindex      packed lane T indices
//   i_rindex      packed lane R indices
//   i_rd_t/i_rd_r read address
//   o_rd_code     code stored at the read address
// ---------------------------------------------------------------------------
module dtw_traceback_mem
  import dtw_traceback_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic [LANES-1:0]        i_we,
  input  logic [LANES*CODE_W-1:0] i_path,
  input  logic [LANES*IDX_W-1:0]  i_tindex,
  input  logic [LANES*IDX_W-1:0]  i_rindex,
  input  logic [IDX_W-1:0]        i_rd_t,
  input  logic [IDX_W-1:0]        i_rd_r,
  output logic [CODE_W-1:0]       o_rd_code
);

  logic [CODE_W-1:0] r_cell [DEPTH][DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int t = 0; t < DEPTH; t++)
        for (int r = 0; r < DEPTH; r++)
          r_cell[t][r] <= PC_NONE;
    end else if (i_clr) begin
      for (int t = 0; t < DEPTH; t++)
        for (int r = 0; r < DEPTH; r++)
          r_cell[t][r] <= PC_NONE;
    end else begin
      // Ascending loop: the last (highest) lane's write to a cell sticks
      for (int k = 0; k < LANES; k++)
        if (i_we[k])
          r_cell[lane_idx(i_tindex, k)][lane_idx(i_rindex, k)] <= lane_code(i_path, k);
    end
  end

  assign o_rd_code = r_cell[i_rd_t][i_rd_r];

endmodule

// File: rtl/dtw_traceback.sv
// ---------------------------------------------------------------------------
// dtw_traceback
// Captures the per-cell predecessor codes streamed by the DTW distance array
// (LANES cells per cycle), then walks back from (tlen,rlen) to (0,0) and
// streams the warp path out over a valid/ready handshake.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   ena                 global enable; 0 freezes all state and outputs
//   i_start             begin a job (honoured in IDLE only)
//   i_tlen, i_rlen      last T / R index of the job
//   i_path              packed lane codes
//   i_tindex, i_rindex  packed lane T / R indices
//   i_rdy               downstream ready
//   o_vld, o_t, o_r     current path point
//   o_last              current point is (0,0)
//   o_plen              points accepted so far in this job
//   o_busy              job in progress
//   o_done              one-cycle pulse after (0,0) is accepted
//   o_err               trace reached an unwritten cell (sticky to next start)
// ---------------------------------------------------------------------------
module dtw_traceback
  import dtw_traceback_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    i_start,
  input  logic [IDX_W-1:0]        i_tlen,
  input  logic [IDX_W-1:0]        i_rlen,
  input  logic [LANES*CODE_W-1:0] i_path,
  input  logic [LANES*IDX_W-1:0]  i_tindex,
  input  logic [LANES*IDX_W-1:0]  i_rindex,
  input  logic                    i_rdy,
  output logic                    o_vld,
  output logic [IDX_W-1:0]        o_t,
  output logic [IDX_W-1:0]        o_r,
  output logic                    o_last,
  output logic [PLEN_W-1:0]       o_plen,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_err
);

  state_e              r_state;
  logic [IDX_W-1:0]    r_tlen;
  logic [IDX_W-1:0]    r_rlen;
  logic [CODE_W-1:0]   r_code;      // code stored at the point on o_t/o_r

  logic [LANES-1:0]    w_we;
  logic                w_clr;
  logic                w_hit_end;
  logic [CODE_W-1:0]   w_end_code;
  logic [CODE_W-1:0]   w_step;
  logic [IDX_W-1:0]    w_nt;
  logic [IDX_W-1:0]    w_nr;
  logic [CODE_W-1:0]   w_nxt_code;
  logic                w_nxt_origin;
  logic                w_accept;

  // Lane qualification; the end cell's code is captured straight off the
  // lanes so the first point can be presented the cycle after its write.
  always_comb begin
    w_we       = '0;
    w_hit_end  = 1'b0;
    w_end_code = PC_NONE;
    for (int k = 0; k < LANES; k++) begin
      if (ena && (r_state == ST_FILL) && (lane_code(i_path, k) != PC_NONE) &&
          (lane_idx(i_tindex, k) <= r_tlen) && (lane_idx(i_rindex, k) <= r_rlen)) begin
        w_we[k] = 1'b1;
        if ((lane_idx(i_tindex, k) == r_tlen) && (lane_idx(i_rindex, k) == r_rlen)) begin
          w_hit_end  = 1'b1;
          w_end_code = lane_code(i_path, k);
        end
      end
    end
  end

  assign w_clr = ena && (r_state == ST_IDLE) && i_start;

  // Next pointer; edges of the grid force the only legal move
  always_comb begin
    if (o_t == '0)
      w_step = PC_LEFT;
    else if (o_r == '0)
      w_step = PC_UP;
    else
      w_step = r_code;
    w_nt = o_t;
    w_nr = o_r;
    case (w_step)
      PC_DIAG: begin
        w_nt = o_t - 1'b1;
        w_nr = o_r - 1'b1;
      end
      PC_UP:   w_nt = o_t - 1'b1;
      PC_LEFT: w_nr = o_r - 1'b1;
      default: ;
    endcase
  end

  assign w_nxt_origin = (w_nt == '0) && (w_nr == '0);
  assign w_accept     = ena && (r_state == ST_TRACE) && o_vld && i_rdy;
  assign o_busy       = (r_state != ST_IDLE);

  // The read port looks ahead at the next pointer so a bad cell is caught
  // before it is ever presented.
  dtw_traceback_mem u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_clr),
    .i_we      (w_we),
    .i_path    (i_path),
    .i_tindex  (i_tindex),
    .i_rindex  (i_rindex),
    .i_rd_t    (w_nt),
    .i_rd_r    (w_nr),
    .o_rd_code (w_nxt_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_tlen  <= '0;
      r_rlen  <= '0;
      r_code  <= '0;
      o_vld   <= 1'b0;
      o_t     <= '0;
      o_r     <= '0;
      o_last  <= 1'b0;
      o_plen  <= '0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
    end else if (ena) begin
      o_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_tlen  <= i_tlen;
            r_rlen  <= i_rlen;
            o_err   <= 1'b0;
            o_plen  <= '0;
            r_state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (w_hit_end) begin
            o_vld   <= 1'b1;
            o_t     <= r_tlen;
            o_r     <= r_rlen;
            o_last  <= (r_tlen == '0) && (r_rlen == '0);
            r_code  <= w_end_code;
            r_state <= ST_TRACE;
          end
        end
        ST_TRACE: begin
          if (w_accept) begin
            o_plen <= o_plen + 1'b1;
            if (o_last) begin
              o_vld   <= 1'b0;
              o_last  <= 1'b0;
              o_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else if ((w_nxt_code == PC_NONE) && !w_nxt_origin) begin
              o_vld   <= 1'b0;
              o_err   <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              o_t    <= w_nt;
              o_r    <= w_nr;
              r_code <= w_nxt_code;
              o_last <= w_nxt_origin;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dtw_traceback.sv
module tb_dtw_traceback;
  import dtw_traceback_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b1;
  logic        i_start = 1'b0;
  logic [4:0]  i_tlen = '0;
  logic [4:0]  i_rlen = '0;
  logic [11:0] i_path = '1;
  logic [29:0] i_tindex = '0;
  logic [29:0] i_rindex = '0;
  logic        i_rdy = 1'b1;
  logic        o_vld;
  logic [4:0]  o_t;
  logic [4:0]  o_r;
  logic        o_last;
  logic [5:0]  o_plen;
  logic        o_busy;
  logic        o_done;
  logic        o_err;

  always #5 clk = ~clk;

  dtw_traceback dut (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .i_start  (i_start),
    .i_tlen   (i_tlen),
    .i_rlen   (i_rlen),
    .i_path   (i_path),
    .i_tindex (i_tindex),
    .i_rindex (i_rindex),
    .i_rdy    (i_rdy),
    .o_vld    (o_vld),
    .o_t      (o_t),
    .o_r      (o_r),
    .o_last   (o_last),
    .o_plen   (o_plen),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_err    (o_err)
  );

  typedef struct packed {
    logic [4:0] t;
    logic [4:0] r;
    logic       last;
    logic [5:0] plen;
  } pt_t;

  pt_t        exp_q[$];
  int         total = 0;
  int         bad = 0;
  logic [1:0] grid [0:31][0:31];
  logic       pat [0:3] = '{1'b1, 1'b0, 1'b0, 1'b1};
  bit         done_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops one expected point per handshake
  logic       stall_prev = 1'b0;
  logic [4:0] st_t = '0;
  logic [4:0] st_r = '0;
  always @(negedge clk) begin : mon
    pt_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else if (ena) begin
      if (stall_prev) begin
        chk("stall_vld", o_vld, 1);
        chk("stall_t", o_t, st_t);
        chk("stall_r", o_r, st_r);
      end
      if (o_vld && i_rdy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_point: got (%0d,%0d) expected no point", o_t, o_r);
        end else begin
          e = exp_q.pop_front();
          chk("pt_t", o_t, e.t);
          chk("pt_r", o_r, e.r);
          chk("pt_last", o_last, e.last);
          chk("pt_plen", o_plen, e.plen);
        end
      end
      stall_prev = o_vld && !i_rdy;
      st_t = o_t;
      st_r = o_r;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_lanes;
    i_path   = '1;
    i_tindex = '0;
    i_rindex = '0;
  endtask

  task automatic put(input int k, input logic [1:0] c, input logic [4:0] t, input logic [4:0] r);
    i_path[(5-k)*2 +: 2]   = c;
    i_tindex[(5-k)*5 +: 5] = t;
    i_rindex[(5-k)*5 +: 5] = r;
  endtask

  task automatic push_pt(input logic [4:0] t, input logic [4:0] r, input logic last, input logic [5:0] plen);
    pt_t e;
    e.t = t; e.r = r; e.last = last; e.plen = plen;
    exp_q.push_back(e);
  endtask

  task automatic set_grid(input int tl, input int rl, input logic [1:0] c);
    for (int t = 0; t < 32; t++)
      for (int r = 0; r < 32; r++)
        grid[t][r] = (t <= tl && r <= rl) ? c : 2'b11;
  endtask

  task automatic start_job(input logic [4:0] tl, input logic [4:0] rl);
    i_tlen  = tl;
    i_rlen  = rl;
    i_start = 1'b1;
    tick;
    i_start = 1'b0;
    chk("start_busy", o_busy, 1);
    chk("start_plen", o_plen, 0);
    chk("start_err", o_err, 0);
  endtask

  // Row-major, written cells packed 6 per cycle; end cell lands last
  task automatic fill_grid(input int tl, input int rl);
    int k;
    k = 0;
    clear_lanes;
    for (int t = 0; t <= tl; t++)
      for (int r = 0; r <= rl; r++)
        if (grid[t][r] != 2'b11) begin
          put(k, grid[t][r], 5'(t), 5'(r));
          k++;
          if (k == 6) begin
            tick;
            clear_lanes;
            k = 0;
          end
        end
    if (k != 0) begin
      tick;
      clear_lanes;
    end
  endtask

  // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: ena dropped every 3rd cycle
  task automatic run_trace(input int mode);
    done_seen = 1'b0;
    for (int i = 0; i < 40 && o_busy; i++) begin
      case (mode)
        1:       i_rdy = pat[i % 4];
        2:       ena = ((i % 3) != 1);
        default: i_rdy = 1'b1;
      endcase
      tick;
      if (o_done) done_seen = 1'b1;
    end
    ena   = 1'b1;
    i_rdy = 1'b1;
    chk("trace_ends", o_busy, 0);
    chk("q_empty", exp_q.size(), 0);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_vld"}, o_vld, 0);
    chk({tag, "_t"}, o_t, 0);
    chk({tag, "_r"}, o_r, 0);
    chk({tag, "_last"}, o_last, 0);
    chk({tag, "_plen"}, o_plen, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
    chk({tag, "_err"}, o_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst = 1'b1;
    repeat (3) tick;
    check_idle_zero("reset");
    rst = 1'b0;
    tick;

    // 1: 3x3 all DIAG, ready always high
    start_job(5'd2, 5'd2);
    set_grid(2, 2, 2'b00);
    push_pt(5'd2, 5'd2, 1'b0, 6'd0);
    push_pt(5'd1, 5'd1, 1'b0, 6'd1);
    push_pt(5'd0, 5'd0, 1'b1, 6'd2);
    fill_grid(2, 2);
    chk("t1_first_vld", o_vld, 1);
    run_trace(0);
    chk("t1_done", done_seen, 1);
    chk("t1_plen", o_plen, 3);
    chk("t1_err", o_err, 0);
    tick;
    chk("t1_done_pulse", o_done, 0);

    // 2: tlen=3 rlen=1, UP at (3,1),(2,1), DIAG elsewhere; ena toggling
    start_job(5'd3, 5'd1);
    set_grid(3, 1, 2'b00);
    grid[3][1] = 2'b01;
    grid[2][1] = 2'b01;
    push_pt(5'd3, 5'd1, 1'b0, 6'd0);
    push_pt(5'd2, 5'd1, 1'b0, 6'd1);
    push_pt(5'd1, 5'd1, 1'b0, 6'd2);
    push_pt(5'd0, 5'd0, 1'b1, 6'd3);
    fill_grid(3, 1);
    chk("t2_first_vld", o_vld, 1);
    run_trace(2);
    chk("t2_done", done_seen, 1);
    chk("t2_plen", o_plen, 4);

    // 3: case 1 with ready stalls
    start_job(5'd2, 5'd2);
    set_grid(2, 2, 2'b00);
    push_pt(5'd2, 5'd2, 1'b0, 6'd0);
    push_pt(5'd1, 5'd1, 1'b0, 6'd1);
    push_pt(5'd0, 5'd0, 1'b1, 6'd2);
    fill_grid(2, 2);
    run_trace(1);
    chk("t3_done", done_seen, 1);
    chk("t3_plen", o_plen, 3);

    // 4: (1,1) never written -> error after (2,2)
    start_job(5'd2, 5'd2);
    set_grid(2, 2, 2'b00);
    grid[1][1] = 2'b11;
    push_pt(5'd2, 5'd2, 1'b0, 6'd0);
    fill_grid(2, 2);
    run_trace(0);
    chk("t4_err", o_err, 1);
    chk("t4_no_done", done_seen, 0);
    chk("t4_vld", o_vld, 0);
    chk("t4_plen", o_plen, 1);
    tick;
    chk("t4_err_sticky", o_err, 1);

    // 5: lane priority and out-of-range lanes
    start_job(5'd2, 5'd2);
    clear_lanes;
    put(0, 2'b01, 5'd0, 5'd0);
    put(1, 2'b00, 5'd0, 5'd1);
    put(2, 2'b00, 5'd7, 5'd0);
    put(3, 2'b00, 5'd0, 5'd2);
    put(4, 2'b00, 5'd1, 5'd0);
    put(5, 2'b10, 5'd0, 5'd0);
    tick;
    clear_lanes;
    put(0, 2'b00, 5'd1, 5'd1);
    put(1, 2'b00, 5'd1, 5'd2);
    put(2, 2'b00, 5'd2, 5'd0);
    put(3, 2'b00, 5'd2, 5'd1);
    tick;
    chk("t5_still_fill", o_vld, 0);
    clear_lanes;
    put(0, 2'b01, 5'd2, 5'd2);
    put(1, 2'b00, 5'd9, 5'd9);
    put(5, 2'b10, 5'd2, 5'd2);
    push_pt(5'd2, 5'd2, 1'b0, 6'd0);
    push_pt(5'd2, 5'd1, 1'b0, 6'd1);
    push_pt(5'd1, 5'd0, 1'b0, 6'd2);
    push_pt(5'd0, 5'd0, 1'b1, 6'd3);
    tick;
    clear_lanes;
    chk("t5_first_vld", o_vld, 1);
    run_trace(0);
    chk("t5_done", done_seen, 1);

    // 6: reset mid-trace, frozen start, then single-cell job
    start_job(5'd2, 5'd2);
    set_grid(2, 2, 2'b00);
    push_pt(5'd2, 5'd2, 1'b0, 6'd0);
    fill_grid(2, 2);
    i_rdy = 1'b1;
    tick;
    i_rdy = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    check_idle_zero("t6_rst");
    tick;
    rst = 1'b0;
    i_rdy = 1'b1;
    tick;
    ena     = 1'b0;
    i_start = 1'b1;
    i_tlen  = 5'd3;
    repeat (3) tick;
    i_start = 1'b0;
    ena     = 1'b1;
    tick;
    check_idle_zero("t6_frozen");
    start_job(5'd0, 5'd0);
    clear_lanes;
    put(0, 2'b00, 5'd0, 5'd0);
    push_pt(5'd0, 5'd0, 1'b1, 6'd0);
    tick;
    clear_lanes;
    chk("t6_first_vld", o_vld, 1);
    chk("t6_first_last", o_last, 1);
    run_trace(0);
    chk("t6_done", done_seen, 1);
    chk("t6_plen", o_plen, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
